// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers execute results, runs byte/word loads
// and stores over the req/ack data-memory bus, stalls upstream while an access
// is outstanding and presents registered write-back results.
module mem_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_MEM_dmemWe,
    input  logic        i_MEM_regWe,
    input  logic        i_MEM_sByte,
    input  logic        i_MEM_sWRD,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_aluOut,
    input  logic [31:0] i_MEM_rd2,
    output logic        o_MEM_stall,
    mem_stage_if.master dmem,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_wbData,
    output logic        o_MEM_err
);

    localparam int CNT_RAW_W = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_W     = (CNT_RAW_W > 8) ? CNT_RAW_W : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic        dmem_we;
        logic        reg_we;
        logic        s_byte;
        logic        s_wrd;
        logic [4:0]  wra;
        logic [31:0] alu_out;
        logic [31:0] rd2;
    } stage_t;

    // Byte lane select for stores; word accesses ignore the low address bits.
    function automatic logic [3:0] byte_enable(input logic [1:0] lane, input logic s_byte);
        if (s_byte) begin
            return 4'b0001 << lane;
        end else begin
            return 4'hF;
        end
    endfunction

    // Load data alignment: byte loads are zero-extended from the addressed lane.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  lane,
                                                 input logic        s_byte);
        logic [7:0] byte_v;
        byte_v = rdata[{lane, 3'b000} +: 8];
        if (s_byte) begin
            return {24'h000000, byte_v};
        end else begin
            return rdata;
        end
    endfunction

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    stage_t           stage_r, stage_in_s;
    logic             in_mem_op_s;
    logic             r_load_s;
    logic             busy_s;
    logic             stall_s;
    logic             wb_we_r;
    logic [4:0]       wb_wra_r;
    logic [31:0]      wb_data_r;

    // Gather the execute-stage outputs into one stage-register image.
    always_comb begin
        stage_in_s         = '0;
        stage_in_s.dmem_we = i_MEM_dmemWe;
        stage_in_s.reg_we  = i_MEM_regWe;
        stage_in_s.s_byte  = i_MEM_sByte;
        stage_in_s.s_wrd   = i_MEM_sWRD;
        stage_in_s.wra     = i_MEM_WRA;
        stage_in_s.alu_out = i_MEM_aluOut;
        stage_in_s.rd2     = i_MEM_rd2;
    end

    assign in_mem_op_s = i_MEM_dmemWe | i_MEM_sWRD;
    assign r_load_s    = stage_r.s_wrd & ~stage_r.dmem_we;
    assign busy_s      = (state_r == ST_BUSY);
    assign stall_s     = (busy_s & ~dmem.ack) | (state_r == ST_ERR);
    assign o_MEM_stall = stall_s;
    assign o_MEM_err   = (state_r == ST_ERR);

    // Stage register: advance whenever the stage is not stalling upstream.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_r <= '0;
        end else if (!stall_s) begin
            stage_r <= stage_in_s;
        end else begin
            stage_r <= stage_r;
        end
    end

    // Next state and timeout counter; a new mem op captured on the ack edge keeps us BUSY.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cnt_inc_s   = (cnt_r != CNT_MAX) ? (cnt_r + CNT_ONE) : cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (in_mem_op_s) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (dmem.ack) begin
                    if (in_mem_op_s) begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (cnt_inc_s == CNT_LIMIT) begin
                    state_nxt_s = ST_ERR;
                    cnt_nxt_s   = cnt_inc_s;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers; only reset leaves ERR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Bus outputs come straight from the stage register and are held quiet when idle.
    always_comb begin
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.addr  = 32'h0000_0000;
        dmem.be    = 4'h0;
        dmem.wdata = 32'h0000_0000;
        if (busy_s) begin
            dmem.req   = 1'b1;
            dmem.we    = stage_r.dmem_we;
            dmem.addr  = {stage_r.alu_out[31:2], 2'b00};
            dmem.be    = byte_enable(stage_r.alu_out[1:0], stage_r.s_byte);
            dmem.wdata = stage_r.s_byte ? {4{stage_r.rd2[7:0]}} : stage_r.rd2;
        end else begin
            dmem.req   = 1'b0;
        end
    end

    // Write-back register: retire non-mem ops from IDLE, mem ops on ack, bubble otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_we_r   <= 1'b0;
            wb_wra_r  <= 5'd0;
            wb_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wb_we_r   <= stage_r.reg_we;
                    wb_wra_r  <= stage_r.wra;
                    wb_data_r <= stage_r.alu_out;
                end
                ST_BUSY: begin
                    if (dmem.ack) begin
                        wb_we_r   <= stage_r.reg_we;
                        wb_wra_r  <= stage_r.wra;
                        wb_data_r <= r_load_s ? load_extract(dmem.rdata, stage_r.alu_out[1:0], stage_r.s_byte)
                                              : stage_r.alu_out;
                    end else begin
                        wb_we_r   <= 1'b0;
                    end
                end
                default: begin
                    wb_we_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_MEM_regWe  = wb_we_r;
    assign o_MEM_WRA    = wb_wra_r;
    assign o_MEM_wbData = wb_data_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a memory responder with programmable ack
// delay, a write-back scoreboard, and directed scenarios for ALU ops, word/byte
// loads and stores, back-to-back accesses, bus timeout and reset.
module tb_mem_stage;
    localparam int ACK_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_MEM_dmemWe, i_MEM_regWe, i_MEM_sByte, i_MEM_sWRD;
    logic [4:0]  i_MEM_WRA;
    logic [31:0] i_MEM_aluOut, i_MEM_rd2;
    logic        o_MEM_stall, o_MEM_regWe, o_MEM_err;
    logic [4:0]  o_MEM_WRA;
    logic [31:0] o_MEM_wbData;

    mem_stage_if bus();

    mem_stage #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_MEM_dmemWe (i_MEM_dmemWe),
        .i_MEM_regWe  (i_MEM_regWe),
        .i_MEM_sByte  (i_MEM_sByte),
        .i_MEM_sWRD   (i_MEM_sWRD),
        .i_MEM_WRA    (i_MEM_WRA),
        .i_MEM_aluOut (i_MEM_aluOut),
        .i_MEM_rd2    (i_MEM_rd2),
        .o_MEM_stall  (o_MEM_stall),
        .dmem         (bus),
        .o_MEM_regWe  (o_MEM_regWe),
        .o_MEM_WRA    (o_MEM_WRA),
        .o_MEM_wbData (o_MEM_wbData),
        .o_MEM_err    (o_MEM_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wra;
        logic [31:0] data;
    } wb_t;

    wb_t         exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          ack_delay = 0;
    bit          no_ack = 1'b0;
    logic [31:0] rdata_val = 32'h0000_0000;
    int          wcnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after ack_delay stalled cycles, driven on the falling edge.
    initial begin
        bus.ack   = 1'b0;
        bus.rdata = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (!bus.req || bus.ack) wcnt = 0;
            if (bus.req && !no_ack && wcnt >= ack_delay) begin
                bus.ack   = 1'b1;
                bus.rdata = rdata_val;
            end else begin
                bus.ack   = 1'b0;
                bus.rdata = 32'h0BAD_0BAD;
                if (bus.req) wcnt++;
            end
        end
    end

    // Write-back scoreboard: every retired register write must match the next expectation.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && o_MEM_regWe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wb_wra", {59'd0, o_MEM_WRA}, {59'd0, e.wra});
                    check_eq("wb_data", {32'd0, o_MEM_wbData}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic drive_idle();
        #1;
        i_MEM_dmemWe = 1'b0; i_MEM_regWe = 1'b0; i_MEM_sByte = 1'b0; i_MEM_sWRD = 1'b0;
        i_MEM_WRA = 5'd0; i_MEM_aluOut = 32'h0; i_MEM_rd2 = 32'h0;
    endtask

    // Present one op and hold it until the stage captures it; returns on the capture edge.
    task automatic drive_op(input logic dwe, input logic rwe, input logic sb, input logic swrd,
                            input logic [4:0] wra, input logic [31:0] alu, input logic [31:0] rd2,
                            input bit expect_wb, output int waits);
        wb_t         e;
        logic [31:0] ld;
        logic        s;
        @(negedge clk); #1;
        i_MEM_dmemWe = dwe; i_MEM_regWe = rwe; i_MEM_sByte = sb; i_MEM_sWRD = swrd;
        i_MEM_WRA = wra; i_MEM_aluOut = alu; i_MEM_rd2 = rd2;
        if (expect_wb) begin
            ld = sb ? ((rdata_val >> {alu[1:0], 3'b000}) & 32'h0000_00FF) : rdata_val;
            e.wra  = wra;
            e.data = (swrd && !dwe) ? ld : alu;
            exp_q.push_back(e);
        end
        waits = 0;
        #3; s = o_MEM_stall;
        forever begin
            @(posedge clk);
            waits++;
            if (!s) break;
            if (waits >= 2000) begin
                check_eq("capture_timeout", 64'(waits), 64'd0);
                break;
            end
            @(negedge clk); #2; s = o_MEM_stall;
        end
    endtask

    function automatic logic [113:0] all_outs();
        return {o_MEM_stall, bus.req, bus.we, bus.addr, bus.be, bus.wdata,
                o_MEM_regWe, o_MEM_WRA, o_MEM_wbData, o_MEM_err};
    endfunction

    initial begin
        int w, n;
        rstn = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        check_eq("reset_outputs", 64'(all_outs() != 114'd0), 64'd0);
        check_eq("reset_err", {63'd0, o_MEM_err}, 64'd0);
        @(negedge clk); rstn = 1'b1;

        // ALU op: one-cycle latency, never stalls
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 1'b1, w);
        check_eq("alu_waits", 64'(w), 64'd1);
        drive_idle();
        @(negedge clk); #1;
        check_eq("alu_stall0", {63'd0, o_MEM_stall}, 64'd0);
        check_eq("alu_wb_not_yet", {63'd0, o_MEM_regWe}, 64'd0);
        @(negedge clk); #1;
        check_eq("alu_wb_regwe", {63'd0, o_MEM_regWe}, 64'd1);
        check_eq("alu_wb_data", {32'd0, o_MEM_wbData}, 64'h1234);
        check_eq("alu_stall1", {63'd0, o_MEM_stall}, 64'd0);

        // Word load, ack after 3 stalled cycles
        ack_delay = 3; rdata_val = 32'hDEAD_BEEF;
        drive_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0100, 32'h0, 1'b1, w);
        drive_idle();
        @(negedge clk); #1;
        check_eq("wl_req", {63'd0, bus.req}, 64'd1);
        check_eq("wl_we", {63'd0, bus.we}, 64'd0);
        check_eq("wl_addr", {32'd0, bus.addr}, 64'h100);
        check_eq("wl_be", {60'd0, bus.be}, 64'hF);
        n = 0;
        while (o_MEM_stall && n < 100) begin n++; @(negedge clk); #1; end
        check_eq("wl_stall_cycles", 64'(n), 64'd3);
        @(negedge clk); #1;
        check_eq("wl_wb_regwe", {63'd0, o_MEM_regWe}, 64'd1);
        check_eq("wl_wb_data", {32'd0, o_MEM_wbData}, 64'hDEAD_BEEF);
        check_eq("wl_req_done", {63'd0, bus.req}, 64'd0);

        // Byte load from lane 3, ack in the first busy cycle
        ack_delay = 0; rdata_val = 32'hAABB_CCDD;
        drive_op(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0103, 32'h0, 1'b1, w);
        drive_idle();
        @(negedge clk); #1;
        check_eq("bl_be", {60'd0, bus.be}, 64'h8);
        check_eq("bl_addr", {32'd0, bus.addr}, 64'h100);
        @(negedge clk); #1;
        check_eq("bl_wb_data", {32'd0, o_MEM_wbData}, 64'h0000_00AA);

        // Byte store to lane 2: replicated data, no register write
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0102, 32'h0000_0055, 1'b0, w);
        drive_idle();
        @(negedge clk); #1;
        check_eq("bs_we", {63'd0, bus.we}, 64'd1);
        check_eq("bs_be", {60'd0, bus.be}, 64'h4);
        check_eq("bs_wdata", {32'd0, bus.wdata}, 64'h5555_5555);
        @(negedge clk); #1;
        check_eq("bs_regwe", {63'd0, o_MEM_regWe}, 64'd0);

        // Back-to-back word load then misaligned word store, ack held high
        rdata_val = 32'h1122_3344;
        drive_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0200, 32'h0, 1'b1, w);
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0206, 32'hCAFE_F00D, 1'b0, w);
        check_eq("b2b_store_waits", 64'(w), 64'd1);
        drive_idle();
        @(negedge clk); #1;
        check_eq("b2b_req", {63'd0, bus.req}, 64'd1);
        check_eq("b2b_we", {63'd0, bus.we}, 64'd1);
        check_eq("b2b_addr", {32'd0, bus.addr}, 64'h204);
        check_eq("b2b_be", {60'd0, bus.be}, 64'hF);
        check_eq("b2b_wdata", {32'd0, bus.wdata}, 64'hCAFE_F00D);
        check_eq("b2b_load_wb", {32'd0, o_MEM_wbData}, 64'h1122_3344);

        // Load never acknowledged: timeout into sticky ERR
        no_ack = 1'b1;
        drive_op(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0300, 32'h0, 1'b0, w);
        drive_idle();
        n = 0;
        @(negedge clk); #1;
        while (!o_MEM_err && n < 1000) begin
            if (bus.req) n++;
            @(negedge clk); #1;
        end
        check_eq("to_busy_cycles", 64'(n), 64'(ACK_TIMEOUT));
        check_eq("to_err", {63'd0, o_MEM_err}, 64'd1);
        check_eq("to_req", {63'd0, bus.req}, 64'd0);
        check_eq("to_stall", {63'd0, o_MEM_stall}, 64'd1);
        check_eq("to_regwe", {63'd0, o_MEM_regWe}, 64'd0);
        no_ack = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_eq("to_err_sticky", {63'd0, o_MEM_err}, 64'd1);
        rstn = 1'b0;
        #1;
        check_eq("to_reset_outputs", 64'(all_outs() != 114'd0), 64'd0);
        @(negedge clk); rstn = 1'b1;

        // Recovery after reset
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h0, 1'b1, w);
        check_eq("rec_waits", 64'(w), 64'd1);
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rec_err", {63'd0, o_MEM_err}, 64'd0);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
